mem_fill_arbiter: RTL

- Shares the single-ported unified main memory between the I-cache miss handler (requester I) and the D-cache miss/write-through handler (requester D).
- Sequences each block fill as a burst of word reads and counts the returned data.
- Steers returned words to the owning cache.
- Single-word D-side writes are issued as one-cycle memory transactions.
- Sits between both caches and the memory model, beneath the IF and MEM stages of the 5-stage pipeline.

---
 rtl/mem_fill_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_fill_arbiter.sv
// Shares the single-ported main memory between the I-cache and D-cache miss handlers:
// round-robin arbitration, burst block fills with return counting, single-word D writes.
module mem_fill_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_req,
    input  logic [ADDR_W-1:0]                i_addr,
    input  logic                             d_req,
    input  logic                             d_wr,
    input  logic [ADDR_W-1:0]                d_addr,
    input  logic [DATA_W-1:0]                d_wdata,
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_rvalid,
    output logic [DATA_W-1:0]                fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_idx,
    output logic                             i_fill_vld,
    output logic                             d_fill_vld,
    output logic                             i_done,
    output logic                             d_done,
    output logic                             busy
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] BLK_WORDS = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             OWN_I     = 1'b0;
    localparam logic             OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_iss_cnt;
    logic [CNT_W-1:0]    r_ret_cnt;
    logic [CNT_W-1:0]    w_iss_nxt;
    logic [CNT_W-1:0]    w_ret_nxt;
    logic                r_owner;
    logic                r_last_owner;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_grant;
    logic                w_fill_vld;
    logic                w_done;
    logic                w_mem_en;
    logic                w_mem_wr;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Arbitration: on a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (i_req && d_req) begin
            w_grant_d = (r_last_owner == OWN_I);
            w_grant_i = (r_last_owner == OWN_D);
        end else begin
            w_grant_d = d_req;
            w_grant_i = i_req;
        end
    end

    // Next-state, issue sequencing and return accounting.
    always_comb begin
        w_state_nxt = r_state;
        w_iss_nxt   = r_iss_cnt;
        w_ret_nxt   = r_ret_cnt;
        w_grant     = 1'b0;
        w_fill_vld  = 1'b0;
        w_done      = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                w_iss_nxt = '0;
                w_ret_nxt = '0;
                w_grant   = w_grant_i | w_grant_d;
                if (w_grant) begin
                    w_state_nxt = (w_grant_d && d_wr) ? ST_WRITE : ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (r_iss_cnt < BLK_WORDS) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = {r_base[ADDR_W-1:IDX_W+1], r_iss_cnt[IDX_W-1:0], 1'b0};
                    w_iss_nxt  = r_iss_cnt + CNT_ONE;
                end else begin
                    w_iss_nxt  = r_iss_cnt;
                end
                // Returns arrive in issue order, so the return count is the word index.
                if (mem_rvalid && (r_ret_cnt < BLK_WORDS)) begin
                    w_fill_vld = 1'b1;
                    w_ret_nxt  = r_ret_cnt + CNT_ONE;
                    if (r_ret_cnt == LAST_WORD) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_iss_nxt   = '0;
                        w_ret_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_ret_nxt = r_ret_cnt;
                end
            end
            ST_WRITE: begin
                w_mem_en    = 1'b1;
                w_mem_wr    = 1'b1;
                w_mem_addr  = r_base;
                w_mem_wdata = r_wdata;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_iss_nxt   = '0;
                w_ret_nxt   = '0;
            end
        endcase
    end

    // State, counters and the request latched at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_iss_cnt    <= '0;
            r_ret_cnt    <= '0;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_base       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_iss_cnt <= w_iss_nxt;
            r_ret_cnt <= w_ret_nxt;
            if (w_grant) begin
                r_owner      <= w_grant_d;
                r_last_owner <= w_grant_d;
                r_base       <= w_grant_d ? d_addr : i_addr;
                r_wdata      <= d_wdata;
            end else begin
                r_owner      <= r_owner;
                r_last_owner <= r_last_owner;
                r_base       <= r_base;
                r_wdata      <= r_wdata;
            end
        end
    end

    assign mem_en     = w_mem_en;
    assign mem_wr     = w_mem_wr;
    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;
    assign fill_data  = rst ? '0 : mem_rdata;
    assign fill_idx   = w_fill_vld ? r_ret_cnt[IDX_W-1:0] : '0;
    assign i_fill_vld = w_fill_vld & (r_owner == OWN_I);
    assign d_fill_vld = w_fill_vld & (r_owner == OWN_D);
    assign i_done     = w_done & (r_owner == OWN_I);
    assign d_done     = w_done & (r_owner == OWN_D);
    assign busy       = (r_state != ST_IDLE);

endmodule
